tmds_pll_supervisor: RTL and testbench



---
 rtl/tmds_pll_supervisor.sv | 160 ++++++++++++++++
 tb/tb_tmds_pll_supervisor.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/tmds_pll_supervisor.sv
// Sequences PLL power-down/reset, lock qualification and ordered release of the
// serial and pixel clock-domain resets for a TMDS transmitter, with retry/fault handling.
module tmds_pll_supervisor #(
  parameter int PLL_RST_CYCLES      = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 500000,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int SER_TO_PIX_CYCLES   = 8,
  parameter int MAX_RETRIES         = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       pll_lock,
  output logic       pll_reset,
  output logic       pll_pwd,
  output logic       rst_serial,
  output logic       rst_pixel,
  output logic       ready,
  output logic       fault,
  output logic [3:0] retry_cnt,
  output logic [7:0] lost_lock_cnt
);

  localparam int TO_W  = $clog2(LOCK_TIMEOUT_CYCLES + 1);
  localparam int CNT_W = (TO_W > 20) ? TO_W : 20;

  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] ST_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] S2P_LAST = CNT_W'(SER_TO_PIX_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [2:0] {
    S_OFF, S_PLL_RST, S_WAIT_LOCK, S_STABLE, S_SER_REL, S_RUN, S_FAULT
  } state_t;

  state_t           r_state, w_state_next;
  logic [CNT_W-1:0] r_cnt, w_cnt_next;
  logic             r_sync1, r_sync2;
  logic [3:0]       r_retry, w_retry_next, w_retry_inc;
  logic [7:0]       r_lost, w_lost_next;
  logic             w_pwd, w_reset, w_rs, w_rp, w_ready, w_fault;
  logic             w_lock_s;

  assign w_lock_s    = r_sync2;
  assign w_retry_inc = r_retry + 4'd1;

  always_comb begin
    w_state_next = r_state;
    w_retry_next = r_retry;
    w_lost_next  = r_lost;
    case (r_state)
      S_OFF: if (enable) begin
        w_state_next = S_PLL_RST;
        w_retry_next = 4'd0;
      end
      S_PLL_RST: if (r_cnt == RST_LAST) w_state_next = S_WAIT_LOCK;
      S_WAIT_LOCK: begin
        if (w_lock_s) begin
          w_state_next = S_STABLE;
        end else if (r_cnt == TO_LAST) begin
          w_retry_next = w_retry_inc;
          w_state_next = (w_retry_inc == 4'(MAX_RETRIES)) ? S_FAULT : S_PLL_RST;
        end
      end
      S_STABLE: begin
        if (!w_lock_s)              w_state_next = S_WAIT_LOCK;
        else if (r_cnt == ST_LAST)  w_state_next = S_SER_REL;
      end
      S_SER_REL: begin
        if (!w_lock_s)              w_state_next = S_PLL_RST;
        else if (r_cnt == S2P_LAST) w_state_next = S_RUN;
      end
      S_RUN: if (!w_lock_s) begin
        w_state_next = S_PLL_RST;
        w_retry_next = 4'd0;
        w_lost_next  = (r_lost == 8'hFF) ? r_lost : r_lost + 8'd1;
      end
      S_FAULT: w_state_next = S_FAULT;
      default: w_state_next = S_OFF;
    endcase
    // Shutdown wins over every other transition and leaves the counters alone.
    if (!enable) begin
      w_state_next = S_OFF;
      w_retry_next = r_retry;
      w_lost_next  = r_lost;
    end
  end

  always_comb begin
    if (w_state_next != r_state) w_cnt_next = '0;
    else if (r_cnt == CNT_MAX)   w_cnt_next = r_cnt;
    else                         w_cnt_next = r_cnt + 1'b1;
  end

  // Outputs decode the next state so they are valid in the cycle a state is entered.
  always_comb begin
    w_pwd   = 1'b1;
    w_reset = 1'b1;
    w_rs    = 1'b1;
    w_rp    = 1'b1;
    w_ready = 1'b0;
    w_fault = 1'b0;
    case (w_state_next)
      S_PLL_RST: w_pwd = 1'b0;
      S_WAIT_LOCK, S_STABLE: begin
        w_pwd   = 1'b0;
        w_reset = 1'b0;
      end
      S_SER_REL: begin
        w_pwd   = 1'b0;
        w_reset = 1'b0;
        w_rs    = 1'b0;
      end
      S_RUN: begin
        w_pwd   = 1'b0;
        w_reset = 1'b0;
        w_rs    = 1'b0;
        w_rp    = 1'b0;
        w_ready = 1'b1;
      end
      S_FAULT: w_fault = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_OFF;
      r_cnt         <= '0;
      r_sync1       <= 1'b0;
      r_sync2       <= 1'b0;
      r_retry       <= 4'd0;
      r_lost        <= 8'd0;
      pll_pwd       <= 1'b1;
      pll_reset     <= 1'b1;
      rst_serial    <= 1'b1;
      rst_pixel     <= 1'b1;
      ready         <= 1'b0;
      fault         <= 1'b0;
    end else begin
      r_sync1       <= pll_lock;
      r_sync2       <= r_sync1;
      r_state       <= w_state_next;
      r_cnt         <= w_cnt_next;
      r_retry       <= w_retry_next;
      r_lost        <= w_lost_next;
      pll_pwd       <= w_pwd;
      pll_reset     <= w_reset;
      rst_serial    <= w_rs;
      rst_pixel     <= w_rp;
      ready         <= w_ready;
      fault         <= w_fault;
    end
  end

  assign retry_cnt     = r_retry;
  assign lost_lock_cnt = r_lost;

endmodule

// File: tb/tb_tmds_pll_supervisor.sv
// Directed bench for tmds_pll_supervisor with params 4/32/8/4/2:
// bring-up timing, lock loss in RUN/STABLE, counter saturation, reset and fault.
module tb_tmds_pll_supervisor;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       pll_lock;
  logic       pll_reset, pll_pwd, rst_serial, rst_pixel, ready, fault;
  logic [3:0] retry_cnt;
  logic [7:0] lost_lock_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_lost = 0;

  always #5 clk = ~clk;

  tmds_pll_supervisor #(
    .PLL_RST_CYCLES(4), .LOCK_TIMEOUT_CYCLES(32), .LOCK_STABLE_CYCLES(8),
    .SER_TO_PIX_CYCLES(4), .MAX_RETRIES(2)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .pll_lock(pll_lock),
    .pll_reset(pll_reset), .pll_pwd(pll_pwd), .rst_serial(rst_serial),
    .rst_pixel(rst_pixel), .ready(ready), .fault(fault),
    .retry_cnt(retry_cnt), .lost_lock_cnt(lost_lock_cnt)
  );

  task automatic check_val(input string tag, input int observed, input int expected);
    n_checks++;
    if (observed != expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end else begin
      $display("ok   %s: %0d", tag, observed);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_pwd"},   int'(pll_pwd), 1);
    check_val({tag, "_prst"},  int'(pll_reset), 1);
    check_val({tag, "_rser"},  int'(rst_serial), 1);
    check_val({tag, "_rpix"},  int'(rst_pixel), 1);
    check_val({tag, "_ready"}, int'(ready), 0);
    check_val({tag, "_fault"}, int'(fault), 0);
    check_val({tag, "_retry"}, int'(retry_cnt), 0);
    check_val({tag, "_lost"},  int'(lost_lock_cnt), 0);
  endtask

  // Samples the current cycle first, then advances; stops at ready or budget.
  task automatic bring_up(input string tag, input int budget, input bit verbose);
    int n_rst, n_wait, n_ser;
    int inv_bad;
    n_rst = 0; n_wait = 0; n_ser = 0; inv_bad = 0;
    for (int i = 0; i < budget; i++) begin
      if (!pll_pwd && pll_reset)     n_rst++;
      if (!pll_reset && rst_serial)  n_wait++;
      if (!rst_serial && rst_pixel)  n_ser++;
      if (ready && (rst_serial || rst_pixel)) inv_bad++;
      if (!rst_pixel && rst_serial)           inv_bad++;
      if (ready) break;
      tick();
    end
    check_val({tag, "_ready"}, int'(ready), 1);
    check_val({tag, "_invariant"}, inv_bad, 0);
    if (verbose) begin
      check_val({tag, "_pllrst_cycles"}, n_rst, 4);
      check_val({tag, "_wait_stable_cycles"}, n_wait, 9);
      check_val({tag, "_ser_to_pix_cycles"}, n_ser, 4);
    end
  endtask

  task automatic run_glitch(input string tag, input bit verbose);
    int t;
    pll_lock = 1'b0;
    tick();
    pll_lock = 1'b1;
    t = 0;
    while (ready && t < 10) begin
      tick();
      t++;
    end
    exp_lost = (exp_lost == 255) ? 255 : exp_lost + 1;
    check_val({tag, "_lost"}, int'(lost_lock_cnt), exp_lost);
    if (verbose) begin
      check_val({tag, "_ready_drop"}, int'(ready), 0);
      check_val({tag, "_rpix"}, int'(rst_pixel), 1);
      check_val({tag, "_rser"}, int'(rst_serial), 1);
      check_val({tag, "_prst"}, int'(pll_reset), 1);
      check_val({tag, "_retry"}, int'(retry_cnt), 0);
    end
    bring_up(tag, 60, verbose);
  endtask

  initial begin
    int n;
    int n_low;
    bit prev_low, seen_r1;

    // Reset and clean bring-up with constant lock.
    rst = 1'b1; enable = 1'b0; pll_lock = 1'b1;
    tick(); tick(); tick();
    check_reset_outputs("reset");
    rst = 1'b0; enable = 1'b1;
    bring_up("bringup", 100, 1'b1);

    // Single-cycle lock loss in RUN, then full recovery.
    run_glitch("run_loss", 1'b1);

    // Saturation of the lost-lock counter: 256 more losses.
    for (int k = 0; k < 256; k++) run_glitch("loss_loop", 1'b0);
    check_val("lost_saturated", int'(lost_lock_cnt), 255);

    // Shutdown keeps the lost-lock count.
    enable = 1'b0;
    tick();
    check_val("off_ready", int'(ready), 0);
    check_val("off_pwd", int'(pll_pwd), 1);
    check_val("off_lost_kept", int'(lost_lock_cnt), 255);

    // Lock glitch in STABLE at count 5: WAIT_LOCK entry to rst_serial release is 16 cycles.
    tick();
    enable = 1'b1;
    n = 0;
    while (pll_reset && n < 20) begin tick(); n++; end
    check_val("stable_wait_entry", int'(pll_reset), 0);
    n = 0;
    for (int k = 0; k < 4; k++) begin tick(); n++; end
    pll_lock = 1'b0;
    tick(); n++;
    pll_lock = 1'b1;
    while (rst_serial && n < 40) begin tick(); n++; end
    check_val("stable_glitch_cycles", n, 16);
    check_val("stable_glitch_retry", int'(retry_cnt), 0);
    bring_up("stable_glitch", 20, 1'b0);

    // Reset while in RUN with enable still high.
    rst = 1'b1;
    tick();
    check_reset_outputs("rst_in_run");

    // No lock at all: two timeouts then FAULT.
    enable = 1'b0; pll_lock = 1'b0;
    tick();
    rst = 1'b0;
    tick(); tick(); tick();
    enable = 1'b1;
    n_low = 0; prev_low = 1'b0; seen_r1 = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (!pll_reset) n_low++;
      if (prev_low && pll_reset && !fault) begin
        seen_r1 = 1'b1;
        check_val("timeout1_retry", int'(retry_cnt), 1);
      end
      prev_low = !pll_reset;
      if (fault) break;
      tick();
    end
    check_val("timeout1_seen", int'(seen_r1), 1);
    check_val("timeout_wait_cycles", n_low, 64);
    check_val("fault_flag", int'(fault), 1);
    check_val("fault_pwd", int'(pll_pwd), 1);
    check_val("fault_prst", int'(pll_reset), 1);
    check_val("fault_retry", int'(retry_cnt), 2);
    tick(); tick();
    check_val("fault_sticky", int'(fault), 1);
    enable = 1'b0;
    tick();
    check_val("fault_exit", int'(fault), 0);
    check_val("fault_exit_pwd", int'(pll_pwd), 1);
    enable = 1'b1;
    tick();
    check_val("reenable_retry_clr", int'(retry_cnt), 0);
    check_val("reenable_pwd", int'(pll_pwd), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
